ldpc_enc_ctrl_param: RTL and testbench

//  Parametrised successor to the QC-LDPC encoder controller. Sequences one codeword:
//  G-matrix load, DATA_BEATS message beats, wait for the flash controller, then

---
 rtl/ldpc_enc_ctrl_param.sv | 134 +++++++++++++
 tb/tb_ldpc_enc_ctrl_param.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_enc_ctrl_param.sv
// Parametrised QC-LDPC encoder controller: G load, message beats, parity readout, clear.
// Optional abort input enabled by defining LDPC_ENC_ABORT_EN.
module ldpc_enc_ctrl_param #(
  parameter int DATA_BEATS   = 32,
  parameter int PARITY_BEATS = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_start,
  input  logic             en_din,
  input  logic             read_parity,
  input  logic             parity_ready,
`ifdef LDPC_ENC_ABORT_EN
  input  logic             abort,
`endif
  output logic             en_counterROM,
  output logic             en_G,
  output logic             load_g,
  output logic             en_L,
  output logic             en_counterOUT,
  output logic             en_out,
  output logic             done_encode,
  output logic             rst_c,
  output logic [CNT_W-1:0] data_cnt,
  output logic             err_overrun
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ENCODE  = 3'd1;
  localparam logic [2:0] WAIT_RD = 3'd2;
  localparam logic [2:0] PAR_OUT = 3'd3;
  localparam logic [2:0] CLEAR   = 3'd4;

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BEATS - 1);
  localparam logic [CNT_W-1:0] PAR_LAST  = CNT_W'(PARITY_BEATS - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
  logic             err_overrun_q, err_overrun_d;
  logic             abort_req;

  // CLEAR already ends in IDLE, so abort only redirects the busy states.
`ifdef LDPC_ENC_ABORT_EN
  assign abort_req = abort && (state_q != IDLE) && (state_q != CLEAR);
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    data_cnt_d    = data_cnt_q;
    par_cnt_d     = par_cnt_q;
    err_overrun_d = err_overrun_q;
    en_counterROM = 1'b0;
    en_G          = 1'b0;
    load_g        = 1'b0;
    en_L          = 1'b0;
    en_counterOUT = 1'b0;
    en_out        = 1'b0;
    done_encode   = 1'b0;
    rst_c         = 1'b1;
    case (state_q)
      IDLE: begin
        if (en_start) begin
          en_G       = 1'b1;
          load_g     = 1'b1;
          data_cnt_d = '0;
          par_cnt_d  = '0;
          state_d    = ENCODE;
        end
      end
      ENCODE: begin
        if (abort_req) begin
          state_d = CLEAR;
        end else if (en_din) begin
          en_counterROM = 1'b1;
          en_L          = 1'b1;
          en_G          = 1'b1;
          data_cnt_d    = data_cnt_q + 1'b1;
          if (data_cnt_q == DATA_LAST) state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // Late message beats are flagged but never consumed.
        if (en_din) err_overrun_d = 1'b1;
        if (abort_req) begin
          state_d = CLEAR;
        end else begin
          done_encode = 1'b1;
          if (read_parity) begin
            par_cnt_d = '0;
            state_d   = PAR_OUT;
          end
        end
      end
      PAR_OUT: begin
        if (abort_req) begin
          state_d = CLEAR;
        end else if (parity_ready) begin
          en_out        = 1'b1;
          en_counterOUT = 1'b1;
          par_cnt_d     = par_cnt_q + 1'b1;
          if (par_cnt_q == PAR_LAST) state_d = CLEAR;
        end
      end
      CLEAR: begin
        rst_c      = 1'b0;
        data_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      data_cnt_q    <= '0;
      par_cnt_q     <= '0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_cnt_q    <= data_cnt_d;
      par_cnt_q     <= par_cnt_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign data_cnt    = data_cnt_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_ldpc_enc_ctrl_param.sv
// Scoreboard bench for ldpc_enc_ctrl_param (DATA_BEATS=4, PARITY_BEATS=2).
// Define LDPC_ENC_ABORT_EN to also exercise the abort path.
module tb_ldpc_enc_ctrl_param;
  localparam int DB = 4;
  localparam int PB = 2;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_start = 1'b0, en_din = 1'b0, read_parity = 1'b0, parity_ready = 1'b0;
  logic abort = 1'b0;
  logic en_counterROM, en_G, load_g, en_L, en_counterOUT, en_out, done_encode, rst_c;
  logic [CW-1:0] data_cnt;
  logic err_overrun;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ldpc_enc_ctrl_param #(.DATA_BEATS(DB), .PARITY_BEATS(PB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en_start(en_start), .en_din(en_din),
    .read_parity(read_parity), .parity_ready(parity_ready),
`ifdef LDPC_ENC_ABORT_EN
    .abort(abort),
`endif
    .en_counterROM(en_counterROM), .en_G(en_G), .load_g(load_g), .en_L(en_L),
    .en_counterOUT(en_counterOUT), .en_out(en_out), .done_encode(done_encode),
    .rst_c(rst_c), .data_cnt(data_cnt), .err_overrun(err_overrun)
  );

  // {rom, G, load_g, L, cntOUT, out, done, rst_c, overrun, data_cnt}
  logic [16:0] outv;
  assign outv = {en_counterROM, en_G, load_g, en_L, en_counterOUT, en_out,
                 done_encode, rst_c, err_overrun, data_cnt};

  typedef struct {
    logic st, din, rp, rdy, ab;
    logic [16:0] exp;
  } step_t;

  logic [16:0] exp_q[$];

  function automatic logic [16:0] mk(logic rom, logic g, logic lg, logic l, logic co,
                                     logic eo, logic dn, logic rc, logic ov, int c);
    logic [CW-1:0] cc;
    cc = CW'(c);
    return {rom, g, lg, l, co, eo, dn, rc, ov, cc};
  endfunction

  function automatic logic [16:0] x_idle(logic ov, int c);  return mk(0,0,0,0,0,0,0,1,ov,c); endfunction
  function automatic logic [16:0] x_start(logic ov, int c); return mk(0,1,1,0,0,0,0,1,ov,c); endfunction
  function automatic logic [16:0] x_beat(logic ov, int c);  return mk(1,1,0,1,0,0,0,1,ov,c); endfunction
  function automatic logic [16:0] x_wait(logic ov);         return mk(0,0,0,0,0,0,1,1,ov,DB); endfunction
  function automatic logic [16:0] x_par(logic ov);          return mk(0,0,0,0,1,1,0,1,ov,DB); endfunction
  function automatic logic [16:0] x_clear(logic ov, int c); return mk(0,0,0,0,0,0,0,0,ov,c); endfunction

  function automatic step_t s(logic st, logic din, logic rp, logic rdy, logic ab, logic [16:0] e);
    step_t r;
    r.st = st; r.din = din; r.rp = rp; r.rdy = rdy; r.ab = ab; r.exp = e;
    return r;
  endfunction

  // Drive one cycle's inputs on the falling edge and queue the expected outputs.
  task automatic drive(input step_t t);
    @(negedge clk);
    en_start = t.st; en_din = t.din; read_parity = t.rp; parity_ready = t.rdy; abort = t.ab;
    exp_q.push_back(t.exp);
  endtask

  task automatic test_reset();
    logic [16:0] e;
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.push_back(x_idle(0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (outv !== e) begin
      fails++;
      $display("FAIL reset_state got=%h exp=%h", outv, e);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    step_t tbl[$];
    logic [16:0] e;
    tbl.push_back(s(1,0,0,0,0, x_start(0, 0)));
    for (int i = 0; i < DB; i++) tbl.push_back(s(0,1,0,0,0, x_beat(0, i)));
    tbl.push_back(s(0,0,0,0,0, x_wait(0)));
    tbl.push_back(s(0,0,1,0,0, x_wait(0)));
    tbl.push_back(s(0,0,0,1,0, x_par(0)));
    tbl.push_back(s(0,0,0,1,0, x_par(0)));
    tbl.push_back(s(0,0,0,0,0, x_clear(0, DB)));
    tbl.push_back(s(0,0,0,0,0, x_idle(0, 0)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (outv !== e) begin
        fails++;
        $display("FAIL basic step %0d got=%h exp=%h", i, outv, e);
      end
    end
  endtask

  task automatic test_backpressure();
    step_t tbl[$];
    logic [16:0] e;
    tbl.push_back(s(1,0,0,0,0, x_start(0, 0)));
    for (int i = 0; i < DB; i++) tbl.push_back(s(0,1,0,0,0, x_beat(0, i)));
    tbl.push_back(s(0,0,1,0,0, x_wait(0)));
    tbl.push_back(s(0,0,0,1,0, x_par(0)));
    tbl.push_back(s(0,0,0,0,0, x_idle(0, DB)));
    tbl.push_back(s(0,0,0,0,0, x_idle(0, DB)));
    tbl.push_back(s(0,0,0,1,0, x_par(0)));
    tbl.push_back(s(0,0,0,1,0, x_clear(0, DB)));
    tbl.push_back(s(0,0,0,0,0, x_idle(0, 0)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (outv !== e) begin
        fails++;
        $display("FAIL backpressure step %0d got=%h exp=%h", i, outv, e);
      end
    end
  endtask

  // Gapped beats; read_parity and en_start during ENCODE must be ignored.
  task automatic test_gapped();
    step_t tbl[$];
    logic [16:0] e;
    tbl.push_back(s(1,0,0,0,0, x_start(0, 0)));
    tbl.push_back(s(0,1,0,0,0, x_beat(0, 0)));
    tbl.push_back(s(0,0,1,1,0, x_idle(0, 1)));
    tbl.push_back(s(1,1,0,0,0, x_beat(0, 1)));
    tbl.push_back(s(0,1,0,0,0, x_beat(0, 2)));
    tbl.push_back(s(1,0,1,0,0, x_idle(0, 3)));
    tbl.push_back(s(0,1,0,0,0, x_beat(0, 3)));
    tbl.push_back(s(1,0,0,0,0, x_wait(0)));
    tbl.push_back(s(0,0,1,0,0, x_wait(0)));
    tbl.push_back(s(0,0,0,1,0, x_par(0)));
    tbl.push_back(s(0,0,0,1,0, x_par(0)));
    tbl.push_back(s(0,0,0,0,0, x_clear(0, DB)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (outv !== e) begin
        fails++;
        $display("FAIL gapped step %0d got=%h exp=%h", i, outv, e);
      end
    end
  endtask

  // Overrun in WAIT_RD, then a back-to-back codeword with the flag still set.
  task automatic test_overrun();
    step_t tbl[$];
    logic [16:0] e;
    tbl.push_back(s(1,0,0,0,0, x_start(0, 0)));
    for (int i = 0; i < DB; i++) tbl.push_back(s(0,1,0,0,0, x_beat(0, i)));
    tbl.push_back(s(0,1,0,0,0, x_wait(0)));
    tbl.push_back(s(0,1,1,0,0, x_wait(1)));
    tbl.push_back(s(0,0,0,1,0, x_par(1)));
    tbl.push_back(s(0,0,0,1,0, x_par(1)));
    tbl.push_back(s(1,0,0,0,0, x_clear(1, DB)));
    tbl.push_back(s(1,0,0,0,0, x_start(1, 0)));
    for (int i = 0; i < DB; i++) tbl.push_back(s(0,1,0,0,0, x_beat(1, i)));
    tbl.push_back(s(0,0,1,0,0, x_wait(1)));
    tbl.push_back(s(0,0,0,1,0, x_par(1)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (outv !== e) begin
        fails++;
        $display("FAIL overrun step %0d got=%h exp=%h", i, outv, e);
      end
    end
  endtask

  // Continues from mid-PAR_OUT left by test_overrun.
  task automatic test_async_reset();
    step_t tbl[$];
    logic [16:0] e;
    drive(s(0,0,0,1,0, x_par(1)));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (outv !== e) begin
      fails++;
      $display("FAIL async_pre got=%h exp=%h", outv, e);
    end
    rst_n = 1'b0;
    exp_q.push_back(x_idle(0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (outv !== e) begin
      fails++;
      $display("FAIL async_reset got=%h exp=%h", outv, e);
    end
    en_start = 0; en_din = 0; read_parity = 0; parity_ready = 0; abort = 0;
    rst_n = 1'b1;
    tbl.push_back(s(0,0,0,0,0, x_idle(0, 0)));
    tbl.push_back(s(1,0,0,0,0, x_start(0, 0)));
    for (int i = 0; i < DB; i++) tbl.push_back(s(0,1,0,0,0, x_beat(0, i)));
    tbl.push_back(s(0,0,1,0,0, x_wait(0)));
    tbl.push_back(s(0,0,0,1,0, x_par(0)));
    tbl.push_back(s(0,0,0,1,0, x_par(0)));
    tbl.push_back(s(0,0,0,0,0, x_clear(0, DB)));
    tbl.push_back(s(0,0,0,0,0, x_idle(0, 0)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (outv !== e) begin
        fails++;
        $display("FAIL after_reset step %0d got=%h exp=%h", i, outv, e);
      end
    end
  endtask

`ifdef LDPC_ENC_ABORT_EN
  task automatic test_abort();
    step_t tbl[$];
    logic [16:0] e;
    tbl.push_back(s(0,0,0,0,1, x_idle(0, 0)));
    tbl.push_back(s(1,0,0,0,0, x_start(0, 0)));
    tbl.push_back(s(0,1,0,0,0, x_beat(0, 0)));
    tbl.push_back(s(0,1,0,0,0, x_beat(0, 1)));
    tbl.push_back(s(0,1,0,0,1, x_idle(0, 2)));
    tbl.push_back(s(0,0,0,0,0, x_clear(0, 2)));
    tbl.push_back(s(0,0,0,0,0, x_idle(0, 0)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (outv !== e) begin
        fails++;
        $display("FAIL abort step %0d got=%h exp=%h", i, outv, e);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_overrun();
    test_async_reset();
`ifdef LDPC_ENC_ABORT_EN
    test_abort();
`endif
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    checks++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
